// File: rtl/rc_filter_channel_scheduler_if.sv
// rc_filter_channel_scheduler_if
//   Bundles the sample/config/result signals of rc_filter_channel_scheduler.
//   master : driven by the sound sources / controller (ticks, inputs, coefficient writes)
//   slave  : the filter scheduler itself
//   Signals:
//     audio_clk_en  sample tick, one clk wide
//     in_flat       NUM_CH x signed 16-bit inputs, channel k at [16k+15:16k]
//     coef_we       coefficient write strobe
//     coef_addr     channel index for the coefficient write
//     coef_data     alpha, unsigned Q0.16
//     out_flat      NUM_CH x signed 16-bit filtered outputs, same packing
//     busy          sweep in progress
//     done          one-cycle pulse after out_flat update
//     overrun       sticky, tick seen while busy
interface rc_filter_channel_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                   audio_clk_en;
    logic [NUM_CH*16-1:0]   in_flat;
    logic                   coef_we;
    logic [AW-1:0]          coef_addr;
    logic [15:0]            coef_data;
    logic [NUM_CH*16-1:0]   out_flat;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    modport master (
        output audio_clk_en, in_flat, coef_we, coef_addr, coef_data,
        input  out_flat, busy, done, overrun
    );

    modport slave (
        input  audio_clk_en, in_flat, coef_we, coef_addr, coef_data,
        output out_flat, busy, done, overrun
    );
endinterface

// File: rtl/rc_filter_channel_scheduler.sv
// rc_filter_channel_scheduler
//   Shares one first-order RC low-pass update engine (subtract, multiply, accumulate)
//   across NUM_CH audio channels. Every audio_clk_en tick snapshots all inputs, updates
//   each channel in turn (two cycles per channel), then publishes all outputs together.
//   Per-channel alpha (unsigned Q0.16) is writable at run time.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high
//     bus    rc_filter_channel_scheduler_if.slave (tick, inputs, coef port, outputs, status)
module rc_filter_channel_scheduler #(
    parameter int          NUM_CH       = 4,
    parameter int          CLOCK_RATE   = 48000,
    parameter int          SAMPLE_RATE  = 48000,
    parameter logic [15:0] COEF_DEFAULT = 16'd618
) (
    input  logic                           clk,
    input  logic                           reset,
    rc_filter_channel_scheduler_if.slave   bus
);

    localparam int            AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [AW-1:0] LAST_CH = AW'(NUM_CH - 1);

    if (NUM_CH < 1) begin : g_num_ch_check
        $error("rc_filter_channel_scheduler: NUM_CH must be >= 1");
    end
    if (CLOCK_RATE / SAMPLE_RATE < 2 * NUM_CH + 2) begin : g_rate_check
        $error("rc_filter_channel_scheduler: CLOCK_RATE/SAMPLE_RATE too small for NUM_CH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ACC,
        S_PUBLISH
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [AW-1:0]        r_ch;
    logic [15:0]          r_snap  [NUM_CH];
    logic [31:0]          r_yacc  [NUM_CH];
    logic [15:0]          r_alpha [NUM_CH];
    logic [31:0]          r_prod;
    logic [NUM_CH*16-1:0] r_out;
    logic                 r_done;
    logic                 r_overrun;

    logic [15:0]          w_y_hi;
    logic signed [16:0]   w_diff;
    logic [31:0]          w_prod;

    // Engine datapath for the channel currently selected by r_ch.
    // Only the low 32 bits of the 34-bit product ever reach the accumulator, and those
    // bits are identical for a 32-bit wrap-around multiply, so the product is kept at 32 bits.
    always_comb begin
        w_y_hi = r_yacc[r_ch][31:16];
        w_diff = {r_snap[r_ch][15], r_snap[r_ch]} - {w_y_hi[15], w_y_hi};
        w_prod = 32'(w_diff) * 32'({1'b0, r_alpha[r_ch]});
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.audio_clk_en) w_next = S_MUL;
            S_MUL:     w_next = S_ACC;
            S_ACC:     w_next = (r_ch == LAST_CH) ? S_PUBLISH : S_MUL;
            S_PUBLISH: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy     = (r_state != S_IDLE);
        bus.done     = r_done;
        bus.overrun  = r_overrun;
        bus.out_flat = r_out;
    end

    // Datapath / storage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch      <= '0;
            r_prod    <= '0;
            r_out     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_snap[k]  <= '0;
                r_yacc[k]  <= '0;
                r_alpha[k] <= COEF_DEFAULT;
            end
        end else begin
            r_done <= (r_state == S_PUBLISH);

            // A tick outside IDLE is dropped but remembered.
            if (bus.audio_clk_en && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            // MUL samples r_alpha before this write lands, so a write during a
            // channel's MUL cycle only affects the following sweep.
            if (bus.coef_we && (int'(bus.coef_addr) < NUM_CH)) begin
                r_alpha[bus.coef_addr] <= bus.coef_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.audio_clk_en) begin
                        for (int unsigned k = 0; k < NUM_CH; k++) begin
                            r_snap[k] <= bus.in_flat[16*k +: 16];
                        end
                        r_ch <= '0;
                    end
                end
                S_MUL: begin
                    r_prod <= w_prod;
                end
                S_ACC: begin
                    r_yacc[r_ch] <= r_yacc[r_ch] + r_prod;
                    if (r_ch != LAST_CH) begin
                        r_ch <= r_ch + AW'(1);
                    end
                end
                S_PUBLISH: begin
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        r_out[16*k +: 16] <= r_yacc[k][31:16];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc_filter_channel_scheduler.sv
module tb_rc_filter_channel_scheduler;

    localparam int N     = 4;
    localparam int LAT   = 2 * N + 1;
    localparam int ADEF  = 618;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rc_filter_channel_scheduler_if #(.NUM_CH(N)) bus ();

    rc_filter_channel_scheduler #(
        .NUM_CH      (N),
        .CLOCK_RATE  (48000 * 16),
        .SAMPLE_RATE (48000),
        .COEF_DEFAULT(16'd618)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per-channel Q16.16 state and alpha
    int          m_yacc  [N];
    logic [15:0] m_alpha [N];

    function automatic int model_step(input int yacc, input logic signed [15:0] x,
                                      input logic [15:0] a);
        longint y;
        longint d;
        longint p;
        y = longint'(yacc >>> 16);
        d = longint'(x) - y;
        p = d * longint'(a);
        return int'(longint'(yacc) + p);
    endfunction

    function automatic logic signed [15:0] model_out(input int yacc);
        return 16'(yacc >>> 16);
    endfunction

    function automatic logic [N*16-1:0] pack(input int a0, input int a1, input int a2, input int a3);
        logic [N*16-1:0] v;
        v = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        return v;
    endfunction

    function automatic logic signed [15:0] dut_out(input int k);
        return bus.out_flat[16*k +: 16];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_yacc[k]  = 0;
            m_alpha[k] = 16'(ADEF);
        end
    endtask

    task automatic write_coef(input int addr, input logic [15:0] data);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'(addr);
        bus.coef_data = data;
        @(posedge clk); #1;
        bus.coef_we   = 1'b0;
        m_alpha[addr] = data;
    endtask

    // One tick plus full sweep. wr_at/extra_at give the edge index (after the tick
    // edge 0) at which a coefficient write / stray tick is sampled; 0 = none.
    task automatic sweep(input logic [N*16-1:0] ins, input int wr_at, input int wr_addr,
                         input logic [15:0] wr_data, input int extra_at, input string tag);
        logic signed [15:0] prev [N];
        logic signed [15:0] expo [N];
        logic signed [15:0] xin  [N];
        logic [15:0]        au;
        logic [N*16-1:0]    hold_exp;
        int                 done_at;
        int                 done_cnt;

        for (int k = 0; k < N; k++) begin
            xin[k]  = ins[16*k +: 16];
            prev[k] = model_out(m_yacc[k]);
            au      = m_alpha[k];
            // channel k's product is formed at edge 2k+1; an earlier write is visible
            if (wr_at > 0 && wr_addr == k && wr_at <= 2 * k) au = wr_data;
            m_yacc[k] = model_step(m_yacc[k], xin[k], au);
            expo[k]   = model_out(m_yacc[k]);
            hold_exp[16*k +: 16] = prev[k];
        end
        if (wr_at > 0) m_alpha[wr_addr] = wr_data;

        bus.in_flat      = ins;
        bus.audio_clk_en = 1'b1;
        @(posedge clk); #1;
        bus.audio_clk_en = 1'b0;

        done_at  = -1;
        done_cnt = 0;
        for (int n = 1; n <= LAT + 3; n++) begin
            bus.in_flat      = {$urandom, $urandom};
            bus.coef_we      = (n == wr_at);
            bus.coef_addr    = 2'(wr_addr);
            bus.coef_data    = wr_data;
            bus.audio_clk_en = (n == extra_at);
            @(posedge clk); #1;
            bus.coef_we      = 1'b0;
            bus.audio_clk_en = 1'b0;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (n == LAT - 1) begin
                vectors++;
                if (bus.out_flat !== hold_exp) begin
                    miscompares++;
                    $display("FAIL %s hold: out_flat=%h expected %h", tag, bus.out_flat, hold_exp);
                end
                vectors++;
                if (bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy_mid: busy=%b expected 1", tag, bus.busy);
                end
            end
            if (n == LAT) begin
                vectors++;
                if (bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s busy_end: busy=%b expected 0", tag, bus.busy);
                end
            end
        end

        vectors++;
        if (done_at !== LAT) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d expected %0d", tag, done_at, LAT);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt);
        end
        for (int k = 0; k < N; k++) begin
            logic signed [15:0] lo;
            logic signed [15:0] hi;
            lo = (prev[k] < xin[k]) ? prev[k] : xin[k];
            hi = (prev[k] < xin[k]) ? xin[k] : prev[k];
            vectors++;
            if (dut_out(k) !== expo[k]) begin
                miscompares++;
                $display("FAIL %s out%0d: got %0d expected %0d", tag, k, dut_out(k), expo[k]);
            end
            vectors++;
            if (dut_out(k) < lo || dut_out(k) > hi) begin
                miscompares++;
                $display("FAIL %s bound%0d: got %0d expected within [%0d,%0d]",
                         tag, k, dut_out(k), lo, hi);
            end
        end
    endtask

    task automatic check_out(input int k, input int exp_v, input string tag);
        vectors++;
        if (int'(dut_out(k)) !== exp_v) begin
            miscompares++;
            $display("FAIL %s: out%0d=%0d expected %0d", tag, k, dut_out(k), exp_v);
        end
    endtask

    task automatic check_reset_state(input string tag);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overrun !== 1'b0 ||
            bus.out_flat !== '0) begin
            miscompares++;
            $display("FAIL %s: busy=%b done=%b overrun=%b out_flat=%h expected 0 0 0 0",
                     tag, bus.busy, bus.done, bus.overrun, bus.out_flat);
        end
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.audio_clk_en = 1'b0;
        bus.in_flat      = '0;
        bus.coef_we      = 1'b0;
        bus.coef_addr    = '0;
        bus.coef_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_state");
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_step_response();
        int e [3];
        e = '{8192, 12288, 14336};
        write_coef(0, 16'h8000);
        for (int i = 0; i < 3; i++) begin
            sweep(pack(16384, 0, 0, 0), 0, 0, 16'h0, 0, "step");
            check_out(0, e[i], "step_literal");
        end
    endtask

    task automatic test_extremes();
        write_coef(1, 16'hFFFF);
        write_coef(2, 16'h0000);
        sweep(pack(16384, 16384, 1000, 0), 0, 0, 16'h0, 0, "extremes");
        check_out(1, 16383, "alpha_max");
        check_out(2, 0, "alpha_zero");
    endtask

    task automatic test_negative();
        write_coef(3, 16'h8000);
        sweep(pack(16384, 16384, 1000, -32768), 0, 0, 16'h0, 0, "neg1");
        check_out(3, -16384, "neg_first");
        sweep(pack(16384, 16384, 1000, -32768), 0, 0, 16'h0, 0, "neg2");
        check_out(3, -24576, "neg_second");
    endtask

    task automatic test_overrun();
        sweep(pack(-5000, 3000, 1000, 7000), 0, 0, 16'h0, 3, "overrun");
        vectors++;
        if (bus.overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: overrun=%b expected 1", bus.overrun);
        end
        sweep(pack(-5000, 3000, 1000, 7000), 0, 0, 16'h0, 0, "overrun_next");
        vectors++;
        if (bus.overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: overrun=%b expected 1", bus.overrun);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bus.in_flat      = pack(20000, -20000, 12345, -1);
        bus.audio_clk_en = 1'b1;
        @(posedge clk); #1;
        bus.audio_clk_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midsweep_busy: busy=%b expected 1", bus.busy);
        end
        reset = 1'b1;
        #1;
        check_reset_state("midsweep_reset");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("midsweep_no_publish");
        sweep(pack(30000, -30000, 15000, -7000), 0, 0, 16'h0, 0, "after_reset");
    endtask

    task automatic test_coef_timing();
        write_coef(1, 16'hFFFF);
        // write sampled at ch1's product edge -> old alpha this sweep
        sweep(pack(0, 20000, 0, 0), 3, 1, 16'h4000, 0, "coef_late");
        sweep(pack(0, 20000, 0, 0), 0, 0, 16'h0, 0, "coef_late_next");
        // write sampled before ch1's product edge -> used immediately
        sweep(pack(0, -20000, 0, 0), 2, 1, 16'hC000, 0, "coef_early");
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int wr_at;
            if ($urandom_range(0, 1) == 1) begin
                logic [15:0] a;
                a = (it % 7 == 0) ? 16'h0 : 16'($urandom);
                write_coef(int'($urandom_range(0, N - 1)), a);
            end
            wr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, LAT)) : 0;
            sweep({$urandom, $urandom}, wr_at, int'($urandom_range(0, N - 1)),
                  16'($urandom), 0, "random");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_step_response();
        test_extremes();
        test_negative();
        test_overrun();
        test_reset_mid_sweep();
        test_coef_timing();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
